// File: rtl/zc_pkg.sv
// Shared widths and state encoding for the zero-count accumulator.
package zc_pkg;

    localparam int BYTE_W  = 8;
    localparam int CNT_W   = 4;
    localparam int TOTAL_W = 12;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

endpackage

// File: rtl/byte_zero_counter.sv
// Combinational count of the zero bits in one byte (result 0..8).
module byte_zero_counter
    import zc_pkg::*;
(
    input  logic [BYTE_W-1:0] data,
    output logic [CNT_W-1:0]  zeros
);

    logic [BYTE_W-1:0] is_zero;

    genvar gi;
    generate
        for (gi = 0; gi < BYTE_W; gi++) begin : g_bit
            assign is_zero[gi] = ~data[gi];
        end
    endgenerate

    always_comb begin
        zeros = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            zeros = zeros + CNT_W'(is_zero[i]);
        end
    end

endmodule

// File: rtl/zero_count_accumulator.sv
// Accumulates per-byte zero counts over FRAME_LEN bytes and presents the
// frame total and peak through a valid/ready handshake.
module zero_count_accumulator
    import zc_pkg::*;
#(
    parameter int FRAME_LEN = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BYTE_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TOTAL_W-1:0] out_total,
    output logic [CNT_W-1:0]   out_max
);

    localparam int IDX_W = 8;

    state_t             state_reg, state_next;
    logic [TOTAL_W-1:0] total_reg, total_next;
    logic [CNT_W-1:0]   max_reg, max_next;
    logic [IDX_W-1:0]   count_reg, count_next;
    logic [TOTAL_W-1:0] out_total_reg, out_total_next;
    logic [CNT_W-1:0]   out_max_reg, out_max_next;

    logic [CNT_W-1:0]   byte_zeros;
    logic [TOTAL_W-1:0] sum;
    logic [CNT_W-1:0]   peak;
    logic               accept;
    logic               last_byte;

    byte_zero_counter u_counter (
        .data  (in_data),
        .zeros (byte_zeros)
    );

    assign accept    = in_valid && (state_reg == ACCUM);
    assign last_byte = (count_reg == IDX_W'(FRAME_LEN - 1));
    assign sum       = total_reg + TOTAL_W'(byte_zeros);
    assign peak      = (byte_zeros > max_reg) ? byte_zeros : max_reg;

    always_comb begin
        state_next     = state_reg;
        total_next     = total_reg;
        max_next       = max_reg;
        count_next     = count_reg;
        out_total_next = out_total_reg;
        out_max_next   = out_max_reg;
        case (state_reg)
            ACCUM: begin
                if (accept) begin
                    total_next = sum;
                    max_next   = peak;
                    count_next = count_reg + 1'b1;
                    if (last_byte) begin
                        out_total_next = sum;
                        out_max_next   = peak;
                        state_next     = DONE;
                    end
                end
            end
            DONE: begin
                // Running state is cleared only once the result is taken.
                if (out_ready) begin
                    total_next = '0;
                    max_next   = '0;
                    count_next = '0;
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ACCUM;
            total_reg     <= '0;
            max_reg       <= '0;
            count_reg     <= '0;
            out_total_reg <= '0;
            out_max_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            total_reg     <= total_next;
            max_reg       <= max_next;
            count_reg     <= count_next;
            out_total_reg <= out_total_next;
            out_max_reg   <= out_max_next;
        end
    end

    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == DONE);
    assign out_total = out_total_reg;
    assign out_max   = out_max_reg;

endmodule

// File: tb/tb_zero_count_accumulator.sv
// Scoreboard bench: three instances (FRAME_LEN 4, 16, 255) driven by directed
// and random stimulus, checked against a frame-level reference model.
module tb_zero_count_accumulator;

    localparam int NL = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid  [NL];
    logic        in_ready  [NL];
    logic [7:0]  in_data   [NL];
    logic        out_valid [NL];
    logic        out_ready [NL];
    logic [11:0] out_total [NL];
    logic [3:0]  out_max   [NL];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_dut
            zero_count_accumulator #(
                .FRAME_LEN(gi == 0 ? 4 : (gi == 1 ? 16 : 255))
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (in_valid[gi]),
                .in_ready  (in_ready[gi]),
                .in_data   (in_data[gi]),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready[gi]),
                .out_total (out_total[gi]),
                .out_max   (out_max[gi])
            );
        end
    endgenerate

    int total_checks = 0;
    int passes       = 0;

    task automatic check(input string name, input int l,
                         input logic [15:0] act, input logic [15:0] exp);
        total_checks++;
        if (act !== exp)
            $display("FAIL %s lane%0d: got %0d, expected %0d (t=%0t)", name, l, act, exp, $time);
        else
            passes++;
    endtask

    function automatic int flen(input int l);
        case (l)
            0:       return 4;
            1:       return 16;
            default: return 255;
        endcase
    endfunction

    // Reference model: collect whole frames, score them when complete.
    logic [7:0]  fbytes   [NL][256];
    int          fcnt     [NL];
    bit          mdone    [NL];
    bit          acc_seen [NL];
    logic [15:0] exp_q    [NL][$];

    always @(posedge clk or posedge reset) begin
        for (int l = 0; l < NL; l++) begin
            if (reset) begin
                fcnt[l]     = 0;
                mdone[l]    = 0;
                acc_seen[l] = 0;
                exp_q[l].delete();
            end else begin
                acc_seen[l] = 0;
                if (mdone[l]) begin
                    if (out_ready[l]) mdone[l] = 0;
                end else if (in_valid[l]) begin
                    acc_seen[l] = 1;
                    fbytes[l][fcnt[l]] = in_data[l];
                    fcnt[l]++;
                    if (fcnt[l] == flen(l)) begin
                        int tot, mx, z;
                        tot = 0;
                        mx  = 0;
                        for (int i = 0; i < flen(l); i++) begin
                            z = 8 - $countones(fbytes[l][i]);
                            tot += z;
                            if (z > mx) mx = z;
                        end
                        exp_q[l].push_back({tot[11:0], mx[3:0]});
                        mdone[l] = 1;
                        fcnt[l]  = 0;
                    end
                end
            end
        end
    end

    // Monitor: compare outputs each cycle; a result is checked every cycle it is held.
    bit          holding [NL];
    logic [15:0] cur     [NL];

    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (reset) begin
                holding[l] = 0;
            end else begin
                check("in_ready", l, 16'(in_ready[l]), 16'(!mdone[l]));
                check("out_valid", l, 16'(out_valid[l]), 16'(mdone[l]));
                if (out_valid[l]) begin
                    if (!holding[l]) begin
                        if (exp_q[l].size() == 0) begin
                            total_checks++;
                            $display("FAIL unexpected_result lane%0d: got total %0d, expected no result",
                                     l, out_total[l]);
                            cur[l] = 16'hxxxx;
                        end else begin
                            cur[l] = exp_q[l].pop_front();
                        end
                        holding[l] = 1;
                    end
                    check("out_total", l, 16'(out_total[l]), 16'(cur[l][15:4]));
                    check("out_max", l, 16'(out_max[l]), 16'(cur[l][3:0]));
                    if (out_ready[l]) holding[l] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int l, input logic [7:0] d, input int gap);
        bit ok;
        in_valid[l] = 1'b0;
        repeat (gap) tick();
        in_valid[l] = 1'b1;
        in_data[l]  = d;
        ok = 0;
        for (int t = 0; t < 2000; t++) begin
            tick();
            if (acc_seen[l]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total_checks++;
            $display("FAIL accept_timeout lane%0d: byte %02h not accepted, expected acceptance", l, d);
        end
        in_valid[l] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int l = 0; l < NL; l++) begin
            in_valid[l]  = 1'b0;
            in_data[l]   = 8'h00;
            out_ready[l] = 1'b1;
        end
        repeat (3) tick();
        @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            check("reset_out_valid", l, 16'(out_valid[l]), 16'd0);
            check("reset_out_total", l, 16'(out_total[l]), 16'd0);
            check("reset_out_max", l, 16'(out_max[l]), 16'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 16 back-to-back zero bytes, then 255 zero bytes
        for (int i = 0; i < 16; i++) send(1, 8'h00, 0);
        repeat (3) tick();
        for (int i = 0; i < 255; i++) send(2, 8'h00, 0);
        repeat (3) tick();

        // Mixed bytes and gapped bytes on the 4-byte lane
        send(0, 8'hFF, 0); send(0, 8'h0F, 0); send(0, 8'h01, 0); send(0, 8'hFE, 0);
        repeat (3) tick();
        send(0, 8'h00, 2); send(0, 8'hAA, 1); send(0, 8'h00, 3); send(0, 8'hAA, 2);
        repeat (3) tick();

        // Result held with out_ready low while in_valid keeps offering bytes
        out_ready[0] = 1'b0;
        send(0, 8'h12, 0); send(0, 8'h34, 0); send(0, 8'h56, 0); send(0, 8'h78, 0);
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h00;
        repeat (5) tick();
        out_ready[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        send(0, 8'h80, 0); send(0, 8'h00, 0); send(0, 8'hFF, 0); send(0, 8'h3C, 0);
        repeat (3) tick();

        // Reset mid-frame (lane 0) and with a pending result (lane 1)
        out_ready[1] = 1'b0;
        for (int i = 0; i < 16; i++) send(1, 8'($urandom), 0);
        send(0, 8'h00, 0); send(0, 8'h00, 0);
        tick();
        reset = 1'b1;
        #1;
        check("async_reset_out_total", 0, 16'(out_total[0]), 16'd0);
        check("async_reset_out_max", 0, 16'(out_max[0]), 16'd0);
        check("async_reset_out_valid", 1, 16'(out_valid[1]), 16'd0);
        repeat (2) tick();
        reset = 1'b0;
        out_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) send(0, 8'hF0, 0);
        repeat (3) tick();

        // Random traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < 2; l++) begin
                in_valid[l]  = ($urandom_range(0, 3) != 0);
                in_data[l]   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                out_ready[l] = $urandom_range(0, 1) == 1;
            end
            tick();
        end
        for (int l = 0; l < NL; l++) begin
            in_valid[l]  = 1'b0;
            out_ready[l] = 1'b1;
        end
        repeat (5) tick();

        for (int l = 0; l < NL; l++) begin
            check("leftover_expected", l, 16'(exp_q[l].size()), 16'd0);
            check("result_still_pending", l, 16'(holding[l]), 16'd0);
        end
        $display("%0d/%0d checks passed", passes, total_checks);
        $finish;
    end

endmodule

// File: doc/zero_count_accumulator.md
ZERO_COUNT_ACCUMULATOR -- requirements
Module: zero_count_accumulator

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: FRAME_LEN, default 16, bytes per frame, legal range 2..255.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  asynchronous active-high reset.
REQ-005 Port: in_valid  input  1  in_data carries a byte this cycle.
REQ-006 Port: in_ready  output  1  block accepts a byte this cycle.
REQ-007 Port: in_data  input  8  byte whose zero bits are counted.
REQ-008 Port: out_valid  output  1  frame result present on out_total/out_max.
REQ-009 Port: out_ready  input  1  downstream takes the result this cycle.
REQ-010 Port: out_total  output  12  sum of zero bits over the frame.
REQ-011 Port: out_max  output  4  largest per-byte zero count in the frame, 0..8.

Function
REQ-012 A byte SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1.
REQ-013 Per-byte count SHALL be the number of 0 bits in in_data, 0..8, computed combinationally in the acceptance cycle.
REQ-014 States SHALL be ACCUM and DONE; in_ready SHALL equal 1 exactly in ACCUM.
REQ-015 In ACCUM, each accepted byte SHALL add its count to a 12-bit running total, update the running max, and increment a byte counter.
REQ-016 On acceptance of byte number FRAME_LEN, the block SHALL load out_total/out_max with the final values, including that byte, and enter DONE.
REQ-017 On the same edge, the block SHALL set out_valid=1, giving a latency of one cycle after the last byte is accepted.
REQ-018 In DONE, out_valid SHALL stay 1 and out_total/out_max SHALL stay stable until the cycle in which out_ready=1.
REQ-019 On the edge where out_valid=1 and out_ready=1, out_valid SHALL go 0, the running total/max/counter SHALL clear, and the state SHALL return to ACCUM.
REQ-020 in_valid in DONE SHALL be ignored; no byte is consumed and no state changes.
REQ-021 out_ready while out_valid=0 SHALL have no effect.
REQ-022 out_total/out_max SHALL hold the last frame result after the handshake, until the next frame completes; they are meaningful only with out_valid=1.
REQ-023 Idle cycles (in_valid=0) within a frame SHALL not disturb the partial accumulation.
REQ-024 Throughput SHALL be one byte per cycle, with at least one non-accepting cycle (DONE) between frames.
REQ-025 No arithmetic overflow SHALL be possible: the maximum total of 8*255=2040 fits in 12 bits.

Reset
REQ-026 Reset assertion SHALL immediately force: state=ACCUM, out_valid=0, out_total=0, out_max=0, running total/max/counter=0.
REQ-027 Reset mid-frame or in DONE SHALL discard the partial or pending result.
REQ-028 While reset=1, no byte SHALL be accepted.
REQ-029 The first edge after deassertion SHALL be able to accept byte 1 of a new frame.

Structure
REQ-030 A shared package zc_pkg SHALL hold BYTE_W=8, CNT_W=4, TOTAL_W=12, and the ACCUM/DONE state encoding.
REQ-031 Per-byte zero counting SHALL be one sub-module, byte_zero_counter: 8-bit in, 4-bit out, purely combinational.
REQ-032 byte_zero_counter SHALL be instantiated once.
REQ-033 All registers SHALL live in zero_count_accumulator.

Verification
REQ-034 FRAME_LEN=16, 16 back-to-back 0x00 bytes, out_ready=1 -> cycle after 16th accept: out_valid=1, out_total=128, out_max=8; in_ready=0 for one cycle.
REQ-035 FRAME_LEN=4, bytes 0xFF,0x0F,0x01,0xFE -> out_total=0+4+7+1=12, out_max=7.
REQ-036 FRAME_LEN=4, out_ready=0 for 5 cycles after completion, in_valid held 1 with 0x00 -> out_valid, out_total and out_max stable for 5 cycles; in_ready=0; no extra byte counted; next frame is correct after out_ready=1.
REQ-037 FRAME_LEN=4, in_valid gaps between bytes 0x00,0xAA,0x00,0xAA -> out_total=24, out_max=8.
REQ-038 Reset pulse after 2 of 4 bytes, then 4 bytes of 0xF0 -> out_total=16, out_max=4; no stale contribution.
REQ-039 FRAME_LEN=255, all bytes 0x00 -> out_total=2040, out_max=8, no wrap.
